// File: rtl/mem_wb_commit.sv
// MEM/WB pipeline register plus architectural commit of HI/LO and the LL/SC link bit.
// Drives the register-file write port and exposes bypassed HI/LO/LLbit reads to EX/MEM.
module mem_wb_commit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  mem_wd,
    input  logic               mem_wreg,
    input  logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_whilo,
    input  logic [DATA_W-1:0]  mem_hi,
    input  logic [DATA_W-1:0]  mem_lo,
    input  logic               mem_llbit_we,
    input  logic               mem_llbit_value,
    output logic [ADDR_W-1:0]  wb_wd,
    output logic               wb_wreg,
    output logic [DATA_W-1:0]  wb_wdata,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               llbit_o
);

    logic [ADDR_W-1:0] wb_wd_q,          wb_wd_d;
    logic              wb_wreg_q,        wb_wreg_d;
    logic [DATA_W-1:0] wb_wdata_q,       wb_wdata_d;
    logic              wb_whilo_q,       wb_whilo_d;
    logic [DATA_W-1:0] wb_hi_q,          wb_hi_d;
    logic [DATA_W-1:0] wb_lo_q,          wb_lo_d;
    logic              wb_llbit_we_q,    wb_llbit_we_d;
    logic              wb_llbit_value_q, wb_llbit_value_d;

    logic [DATA_W-1:0] hi_reg_q, hi_reg_d;
    logic [DATA_W-1:0] lo_reg_q, lo_reg_d;
    logic              llbit_reg_q, llbit_reg_d;

    logic mem_stalled;
    logic wb_stalled;

    assign mem_stalled = stall[4];
    assign wb_stalled  = stall[5];

    // MEM stalled with WB running must inject a bubble, otherwise WB would commit the same instruction twice.
    always_comb begin
        wb_wd_d          = wb_wd_q;
        wb_wreg_d        = wb_wreg_q;
        wb_wdata_d       = wb_wdata_q;
        wb_whilo_d       = wb_whilo_q;
        wb_hi_d          = wb_hi_q;
        wb_lo_d          = wb_lo_q;
        wb_llbit_we_d    = wb_llbit_we_q;
        wb_llbit_value_d = wb_llbit_value_q;
        if (flush || (mem_stalled && !wb_stalled)) begin
            wb_wd_d          = '0;
            wb_wreg_d        = 1'b0;
            wb_wdata_d       = '0;
            wb_whilo_d       = 1'b0;
            wb_hi_d          = '0;
            wb_lo_d          = '0;
            wb_llbit_we_d    = 1'b0;
            wb_llbit_value_d = 1'b0;
        end else if (!mem_stalled) begin
            wb_wd_d          = mem_wd;
            wb_wreg_d        = mem_wreg;
            wb_wdata_d       = mem_wdata;
            wb_whilo_d       = mem_whilo;
            wb_hi_d          = mem_hi;
            wb_lo_d          = mem_lo;
            wb_llbit_we_d    = mem_llbit_we;
            wb_llbit_value_d = mem_llbit_value;
        end
    end

    // The WB instruction has already committed, so HI/LO update ignores stall and flush.
    always_comb begin
        hi_reg_d    = hi_reg_q;
        lo_reg_d    = lo_reg_q;
        llbit_reg_d = llbit_reg_q;
        if (wb_whilo_q) begin
            hi_reg_d = wb_hi_q;
            lo_reg_d = wb_lo_q;
        end
        if (flush) begin
            llbit_reg_d = 1'b0;
        end else if (wb_llbit_we_q) begin
            llbit_reg_d = wb_llbit_value_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_q          <= '0;
            wb_wreg_q        <= 1'b0;
            wb_wdata_q       <= '0;
            wb_whilo_q       <= 1'b0;
            wb_hi_q          <= '0;
            wb_lo_q          <= '0;
            wb_llbit_we_q    <= 1'b0;
            wb_llbit_value_q <= 1'b0;
            hi_reg_q         <= '0;
            lo_reg_q         <= '0;
            llbit_reg_q      <= 1'b0;
        end else begin
            wb_wd_q          <= wb_wd_d;
            wb_wreg_q        <= wb_wreg_d;
            wb_wdata_q       <= wb_wdata_d;
            wb_whilo_q       <= wb_whilo_d;
            wb_hi_q          <= wb_hi_d;
            wb_lo_q          <= wb_lo_d;
            wb_llbit_we_q    <= wb_llbit_we_d;
            wb_llbit_value_q <= wb_llbit_value_d;
            hi_reg_q         <= hi_reg_d;
            lo_reg_q         <= lo_reg_d;
            llbit_reg_q      <= llbit_reg_d;
        end
    end

    assign wb_wd    = wb_wd_q;
    assign wb_wreg  = wb_wreg_q;
    assign wb_wdata = wb_wdata_q;

    // Forward the not-yet-committed WB value so EX/MEM never sees a stale HI/LO/LLbit.
    assign hi_o    = wb_whilo_q ? wb_hi_q : hi_reg_q;
    assign lo_o    = wb_whilo_q ? wb_lo_q : lo_reg_q;
    assign llbit_o = flush ? 1'b0 : (wb_llbit_we_q ? wb_llbit_value_q : llbit_reg_q);

endmodule

// File: tb/tb_mem_wb_commit.sv
// Directed self-checking bench for mem_wb_commit; expected values are worked out by hand
// from the pipeline/commit rules and written inline next to each vector.
module tb_mem_wb_commit;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  memWd;
    logic        memWreg;
    logic [31:0] memWdata;
    logic        memWhilo;
    logic [31:0] memHi;
    logic [31:0] memLo;
    logic        memLlbitWe;
    logic        memLlbitValue;
    logic [4:0]  wbWd;
    logic        wbWreg;
    logic [31:0] wbWdata;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic        llbitOut;

    int vectorCount;
    int miscompareCount;

    mem_wb_commit #(
        .DATA_W (32),
        .ADDR_W (5),
        .STALL_W(6)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .mem_wd         (memWd),
        .mem_wreg       (memWreg),
        .mem_wdata      (memWdata),
        .mem_whilo      (memWhilo),
        .mem_hi         (memHi),
        .mem_lo         (memLo),
        .mem_llbit_we   (memLlbitWe),
        .mem_llbit_value(memLlbitValue),
        .wb_wd          (wbWd),
        .wb_wreg        (wbWreg),
        .wb_wdata       (wbWdata),
        .hi_o           (hiOut),
        .lo_o           (loOut),
        .llbit_o        (llbitOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompareCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle 1ns past the edge before anything is driven or sampled.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearMem();
        memWd         = '0;
        memWreg       = 1'b0;
        memWdata      = '0;
        memWhilo      = 1'b0;
        memHi         = '0;
        memLo         = '0;
        memLlbitWe    = 1'b0;
        memLlbitValue = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        vectorCount     = 0;
        miscompareCount = 0;
        rst           = 1'b1;
        stall         = 6'b000000;
        flush         = 1'b0;
        memWd         = 5'($urandom);
        memWreg       = 1'b1;
        memWdata      = $urandom;
        memWhilo      = 1'b1;
        memHi         = $urandom;
        memLo         = $urandom;
        memLlbitWe    = 1'b1;
        memLlbitValue = 1'b1;

        // Reset with live MEM inputs must leave everything zero.
        applyStimulus();
        checkOutput("rst_wb_wd",    32'(wbWd),     32'h0);
        checkOutput("rst_wb_wreg",  32'(wbWreg),   32'h0);
        checkOutput("rst_wb_wdata", wbWdata,       32'h0);
        checkOutput("rst_hi",       hiOut,         32'h0);
        checkOutput("rst_lo",       loOut,         32'h0);
        checkOutput("rst_llbit",    32'(llbitOut), 32'h0);
        applyStimulus();
        checkOutput("rst2_wb_wreg", 32'(wbWreg),   32'h0);
        rst = 1'b0;
        clearMem();

        // Plain pass-through.
        memWd    = 5'd3;
        memWreg  = 1'b1;
        memWdata = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("pass_wb_wd",    32'(wbWd),   32'h3);
        checkOutput("pass_wb_wreg",  32'(wbWreg), 32'h1);
        checkOutput("pass_wb_wdata", wbWdata,     32'hDEADBEEF);

        // MEM stalled, WB free: bubble.
        memWd    = 5'd7;
        memWdata = 32'h12345678;
        stall    = 6'b010000;
        applyStimulus();
        checkOutput("bubble_wb_wreg",  32'(wbWreg), 32'h0);
        checkOutput("bubble_wb_wdata", wbWdata,     32'h0);
        checkOutput("bubble_wb_wd",    32'(wbWd),   32'h0);

        stall = 6'b000000;
        applyStimulus();
        checkOutput("recap_wb_wd", 32'(wbWd), 32'h7);

        // Both stalled: hold for every stalled cycle.
        stall    = 6'b110000;
        memWd    = 5'd9;
        memWdata = 32'hAAAA5555;
        for (int i = 0; i < 2; i++) begin
            applyStimulus();
            checkOutput("hold_wb_wd",    32'(wbWd),   32'h7);
            checkOutput("hold_wb_wreg",  32'(wbWreg), 32'h1);
            checkOutput("hold_wb_wdata", wbWdata,     32'h12345678);
        end

        // Write to $0 is passed through untouched.
        stall    = 6'b000000;
        memWd    = 5'd0;
        memWreg  = 1'b1;
        memWdata = 32'h0BADF00D;
        applyStimulus();
        checkOutput("r0_wb_wreg",  32'(wbWreg), 32'h1);
        checkOutput("r0_wb_wd",    32'(wbWd),   32'h0);
        checkOutput("r0_wb_wdata", wbWdata,     32'h0BADF00D);

        // HI/LO bypass, then committed value.
        clearMem();
        memWhilo = 1'b1;
        memHi    = 32'h1;
        memLo    = 32'h2;
        applyStimulus();
        checkOutput("hilo_byp_hi", hiOut, 32'h1);
        checkOutput("hilo_byp_lo", loOut, 32'h2);
        memWhilo = 1'b0;
        memHi    = 32'hFFFF0000;
        memLo    = 32'h0000FFFF;
        applyStimulus();
        checkOutput("hilo_reg_hi", hiOut, 32'h1);
        checkOutput("hilo_reg_lo", loOut, 32'h2);

        // LL sets the link bit; a later flush clears it immediately and in state.
        clearMem();
        memLlbitWe    = 1'b1;
        memLlbitValue = 1'b1;
        applyStimulus();
        checkOutput("ll_byp", 32'(llbitOut), 32'h1);
        clearMem();
        applyStimulus();
        checkOutput("ll_reg", 32'(llbitOut), 32'h1);
        flush = 1'b1;
        #1;
        checkOutput("ll_flush_comb", 32'(llbitOut), 32'h0);
        applyStimulus();
        flush = 1'b0;
        #1;
        checkOutput("ll_flush_reg", 32'(llbitOut), 32'h0);

        // Flush wins over a pending WB link-bit write.
        memLlbitWe    = 1'b1;
        memLlbitValue = 1'b1;
        applyStimulus();
        clearMem();
        flush = 1'b1;
        #1;
        checkOutput("llwe_flush_comb", 32'(llbitOut), 32'h0);
        applyStimulus();
        flush = 1'b0;
        #1;
        checkOutput("llwe_flush_reg", 32'(llbitOut), 32'h0);

        // Flush beats a WB hold, yet the pending HI/LO write still commits.
        memWhilo = 1'b1;
        memHi    = 32'h33;
        memLo    = 32'h44;
        applyStimulus();
        flush    = 1'b1;
        stall    = 6'b110000;
        memWhilo = 1'b0;
        memWreg  = 1'b1;
        memWd    = 5'd4;
        memWdata = 32'h55;
        #1;
        checkOutput("fl_hi_byp", hiOut, 32'h33);
        applyStimulus();
        flush = 1'b0;
        #1;
        checkOutput("fl_wb_wreg", 32'(wbWreg), 32'h0);
        checkOutput("fl_hi_reg",  hiOut,       32'h33);
        checkOutput("fl_lo_reg",  loOut,       32'h44);

        // Reset during a stall still clears all state.
        stall    = 6'b000000;
        memWhilo = 1'b1;
        memHi    = 32'h99;
        memLo    = 32'h88;
        applyStimulus();
        stall = 6'b110000;
        rst   = 1'b1;
        applyStimulus();
        rst = 1'b0;
        checkOutput("rstmid_wb_wreg", 32'(wbWreg), 32'h0);
        checkOutput("rstmid_hi",      hiOut,       32'h0);
        checkOutput("rstmid_lo",      loOut,       32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule

// File: doc/mem_wb_commit.md
Name: mem_wb_commit

Overview:
- MEM/WB pipeline boundary plus architectural commit state.
- Registers MEM-stage results and drives the register-file write port (we/waddr/wdata).
- Owns the HI/LO special registers and the LLbit used by LL/SC.
- Exposes bypassed HI/LO/LLbit read values to EX/MEM.
- Sits directly upstream of the register file. Its outputs feed the register file's write port, whose same-cycle write-to-read bypass depends on them.

Parameters:
- DATA_W, 32, width of GPR/HI/LO data
- ADDR_W, 5, GPR address width
- STALL_W, 6, width of pipeline stall vector (bit 4 = MEM, bit 5 = WB)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  per-stage stall request from pipeline controller
- flush  in  1  exception/eret flush
- mem_wd  in  ADDR_W  destination GPR from MEM
- mem_wreg  in  1  GPR write enable from MEM
- mem_wdata  in  DATA_W  GPR write data from MEM
- mem_whilo  in  1  HI/LO write enable from MEM
- mem_hi  in  DATA_W  HI value from MEM
- mem_lo  in  DATA_W  LO value from MEM
- mem_llbit_we  in  1  LLbit write enable from MEM
- mem_llbit_value  in  1  LLbit value from MEM
- wb_wd  out  ADDR_W  regfile waddr
- wb_wreg  out  1  regfile we
- wb_wdata  out  DATA_W  regfile wdata
- hi_o  out  DATA_W  bypassed HI read value
- lo_o  out  DATA_W  bypassed LO read value
- llbit_o  out  1  bypassed LLbit read value

Behaviour:
- All sequential state updates on posedge clk only. Reset is synchronous and has top priority.
- Internal state: pipeline regs (wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo, wb_llbit_we, wb_llbit_value) and architectural regs hi_reg, lo_reg, llbit_reg.
- Reset: every pipeline reg, hi_reg, lo_reg and llbit_reg is 0. Outputs therefore read 0 the cycle after a reset edge.
- Pipeline reg update, first matching row wins:
  1. flush=1: all pipeline regs cleared to 0 (bubble).
  2. stall[4]=1 and stall[5]=0: all pipeline regs cleared to 0. MEM is held and WB gets a bubble, so no double commit.
  3. stall[4]=1 and stall[5]=1: hold all pipeline regs.
  4. stall[4]=0: capture all mem_* inputs.
- Latency: MEM result appears on wb_* exactly 1 cycle after capture. The GPR write lands in the register file on the following edge.
- HI/LO commit: on each non-reset edge where wb_whilo=1, hi_reg<=wb_hi and lo_reg<=wb_lo. This happens regardless of stall/flush, because the instruction in WB has already committed.
- LLbit commit, first match wins:
  1. flush=1: llbit_reg<=0.
  2. wb_llbit_we=1: llbit_reg<=wb_llbit_value.
  3. Otherwise: hold.
- Bypass reads (combinational):
  - hi_o = wb_whilo ? wb_hi : hi_reg; lo_o likewise.
  - llbit_o = flush ? 0 : (wb_llbit_we ? wb_llbit_value : llbit_reg).
- Simultaneous events:
  - flush with wb_whilo=1: HI/LO still commit, pipeline regs clear.
  - flush with wb_llbit_we=1: LLbit becomes 0 (flush wins).
- wb_wreg=1 with wb_wd=0 is passed through unchanged. The register file discards $0 writes.
- Reset mid-stall or mid-flush: reset wins and all state is 0 next cycle.
- No X propagation: all regs are assigned in every branch.

Test Plan:
1. Reset: assert rst 2 cycles with random mem_* → all wb_*, hi_o, lo_o, llbit_o = 0 after first edge.
2. Pass-through: stall=0, mem_wd=5'd3, mem_wreg=1, mem_wdata=32'hDEADBEEF → next cycle wb_wd=3, wb_wreg=1, wb_wdata=32'hDEADBEEF.
3. Stall bubble/hold:
   - stall=6'b010000 with valid MEM → next cycle wb_wreg=0, wb_wdata=0.
   - stall=6'b110000 → wb_* hold previous value for every stalled cycle.
4. HI/LO bypass and commit: mem_whilo=1, mem_hi=32'h1, mem_lo=32'h2.
   - Cycle after capture: hi_o=1, lo_o=2 via bypass.
   - Next cycle with wb_whilo=0: hi_o=1, lo_o=2 from hi_reg/lo_reg.
5. LL/SC: mem_llbit_we=1, value=1 → llbit_o=1 within 1 cycle. Later flush=1 → llbit_o=0 combinationally and llbit_reg=0 after the edge.
6. Flush priority: flush=1 with stall=6'b110000 and mem_wreg=1 → next cycle wb_wreg=0. A pending wb_whilo=1 still updates hi_reg/lo_reg.
